// File: rtl/player_mover.sv
// player_mover: maze player FSM with memory-checked moves, cooldown and exit detection
module player_mover #(
  parameter int WIDTH = 30,
  parameter int HEIGHT = 40,
  parameter int MOVE_DELAY = 5000000,
  parameter int START_X = 1,
  parameter int START_Y = 1
) (
  input  logic        clock,
  input  logic        globalReset,
  input  logic        maze_valid,
  input  logic        timer_end,
  input  logic [3:0]  direction,
  output logic [10:0] maze_addr,
  input  logic        maze_data,
  output logic [7:0]  player_x,
  output logic [7:0]  player_y,
  output logic        exit_reached,
  output logic        regen_req,
  output logic [7:0]  mazes_complete,
  output logic        busy
);
  localparam int CW = $clog2(MOVE_DELAY + 1);
  localparam logic [CW-1:0] CD = CW'(MOVE_DELAY - 1);
  localparam logic [7:0] SX = 8'(START_X);
  localparam logic [7:0] SY = 8'(START_Y);
  localparam logic [7:0] EX = 8'(WIDTH - 2);
  localparam logic [7:0] EY = 8'(HEIGHT - 1);
  localparam logic [8:0] W9 = 9'(WIDTH);
  localparam logic [8:0] H9 = 9'(HEIGHT);
  typedef enum logic [2:0] {IDLE, WAIT_CMD, CALC, READ, CHECK, COOLDOWN} state_t;
  state_t state;
  logic [3:0] dir;
  logic [7:0] tx, ty;
  logic [8:0] nx, ny;
  logic [CW-1:0] cnt;
  logic pend, need_low;
  function automatic logic [10:0] addr_of(input logic [7:0] x, input logic [7:0] y);
    return 11'(x) + 11'(WIDTH) * 11'(y);
  endfunction
  // one step along the latched direction; a step below zero wraps to 9'h1FF and fails the bound check
  always_comb begin
    nx = {1'b0, player_x} + 9'(dir[3]) - 9'(dir[2]);
    ny = {1'b0, player_y} + 9'(dir[1]) - 9'(dir[0]);
  end
  assign maze_addr = (state == READ || state == CHECK) ? addr_of(tx, ty) : addr_of(player_x, player_y);
  assign busy = state != WAIT_CMD;
  // main FSM: reset first, then game-over freeze, then maze-loss abort, then normal stepping
  always_ff @(posedge clock) begin
    exit_reached <= 1'b0;
    regen_req <= 1'b0;
    if (!maze_valid) need_low <= 1'b0;
    if (!globalReset) begin
      state <= IDLE;
      player_x <= SX;
      player_y <= SY;
      tx <= SX;
      ty <= SY;
      dir <= '0;
      mazes_complete <= '0;
      cnt <= '0;
      pend <= 1'b0;
      need_low <= 1'b0;
    end else if (timer_end) begin
      state <= IDLE;
      pend <= 1'b0;
    end else if (state != IDLE && !maze_valid) begin
      state <= IDLE;
      player_x <= SX;
      player_y <= SY;
      pend <= 1'b0;
    end else begin
      case (state)
        IDLE: if (maze_valid && !need_low) state <= WAIT_CMD;
        WAIT_CMD: if (|direction) begin
          dir <= direction & (~direction + 4'd1);
          state <= CALC;
        end
        CALC: if (nx < W9 && ny < H9) begin
          tx <= nx[7:0];
          ty <= ny[7:0];
          state <= READ;
        end else state <= WAIT_CMD;
        READ: state <= CHECK;
        CHECK: if (maze_data) begin
          player_x <= tx;
          player_y <= ty;
          pend <= tx == EX && ty == EY;
          cnt <= CD;
          state <= COOLDOWN;
        end else state <= WAIT_CMD;
        COOLDOWN: if (pend) begin
          pend <= 1'b0;
          exit_reached <= 1'b1;
          regen_req <= 1'b1;
          mazes_complete <= mazes_complete == 8'd99 ? 8'd99 : mazes_complete + 8'd1;
          player_x <= SX;
          player_y <= SY;
          need_low <= 1'b1;
          state <= IDLE;
        end else if (cnt == '0) state <= WAIT_CMD;
        else cnt <= cnt - 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_player_mover.sv
// tb_player_mover: randomized and directed checks of player_mover against a cell-level model
module tb_player_mover;
  localparam int W = 30;
  localparam int H = 40;
  localparam int MD = 4;
  logic clk, rst_n, maze_valid, timer_end, maze_data, exit_reached, regen_req, busy;
  logic [3:0] direction;
  logic [10:0] maze_addr;
  logic [7:0] player_x, player_y, mazes_complete;
  bit mem [W*H];
  int mx, my, mc, n_tests, n_fail;
  player_mover #(.WIDTH(W), .HEIGHT(H), .MOVE_DELAY(MD), .START_X(1), .START_Y(1)) dut (
    .clock(clk),
    .globalReset(rst_n),
    .maze_valid(maze_valid),
    .timer_end(timer_end),
    .direction(direction),
    .maze_addr(maze_addr),
    .maze_data(maze_data),
    .player_x(player_x),
    .player_y(player_y),
    .exit_reached(exit_reached),
    .regen_req(regen_req),
    .mazes_complete(mazes_complete),
    .busy(busy)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) maze_data <= (maze_addr < W*H) ? mem[maze_addr] : 1'b0;
  initial begin
    #3000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic pos(input string tag);
    chk({tag, "_x"}, player_x, mx);
    chk({tag, "_y"}, player_y, my);
  endtask
  task automatic wait_ready();
    for (int i = 0; i < 40 && busy; i++) tick();
    chk("ready", busy, 0);
  endtask
  task automatic finish_exit();
    chk("exit_early", exit_reached, 0);
    tick();
    mc = mc < 99 ? mc + 1 : 99;
    mx = 1;
    my = 1;
    chk("exit_pulse", exit_reached, 1);
    chk("regen_pulse", regen_req, 1);
    chk("mazes", mazes_complete, mc);
    pos("spawn");
    tick();
    chk("exit_once", exit_reached, 0);
    chk("regen_once", regen_req, 0);
    chk("hold_idle", busy, 1);
    maze_valid = 1'b0;
    tick();
    maze_valid = 1'b1;
    tick();
    chk("rearm", busy, 0);
  endtask
  task automatic do_move(input logic [3:0] d, input bit poke);
    int tx, ty;
    bit inb, acc;
    wait_ready();
    tx = mx;
    ty = my;
    if (d[0]) ty = my - 1;
    else if (d[1]) ty = my + 1;
    else if (d[2]) tx = mx - 1;
    else if (d[3]) tx = mx + 1;
    inb = tx >= 0 && tx < W && ty >= 0 && ty < H;
    acc = inb ? mem[tx + W*ty] : 1'b0;
    direction = d;
    tick();
    direction = 4'b0000;
    if (d == 4'b0000) begin
      chk("nodir_busy", busy, 0);
      chk("nodir_addr", maze_addr, mx + W*my);
    end else begin
      chk("calc_busy", busy, 1);
      chk("calc_addr", maze_addr, mx + W*my);
      tick();
      if (!inb) begin
        chk("reject_busy", busy, 0);
        chk("reject_addr", maze_addr, mx + W*my);
      end else begin
        chk("read_addr", maze_addr, tx + W*ty);
        tick();
        chk("check_x", player_x, mx);
        tick();
        if (acc) begin
          mx = tx;
          my = ty;
        end
        pos("move");
        chk("move_busy", busy, acc);
        if (acc && mx == W-2 && my == H-1) finish_exit();
        else if (acc) begin
          direction = poke ? 4'b1000 : 4'b0000;
          repeat (MD-1) begin
            tick();
            chk("cool_busy", busy, 1);
          end
          direction = 4'b0000;
          tick();
          chk("cool_done", busy, 0);
        end
      end
    end
    pos("after");
  endtask
  task automatic goto(input int x, input int y);
    for (int i = 0; i < 500 && (mx != x || my != y); i++)
      do_move(mx < x ? 4'b1000 : mx > x ? 4'b0100 : my < y ? 4'b0010 : 4'b0001, 1'b0);
  endtask
  initial begin
    n_tests = 0;
    n_fail = 0;
    rst_n = 1'b0;
    maze_valid = 1'b0;
    timer_end = 1'b0;
    direction = 4'b0000;
    foreach (mem[i]) mem[i] = 1'b1;
    mem[1] = 1'b0;
    mx = 1;
    my = 1;
    mc = 0;
    tick();
    tick();
    pos("rst");
    chk("rst_mazes", mazes_complete, 0);
    chk("rst_exit", exit_reached, 0);
    chk("rst_regen", regen_req, 0);
    chk("rst_busy", busy, 1);
    chk("rst_addr", maze_addr, 1 + W);
    rst_n = 1'b1;
    maze_valid = 1'b1;
    tick();
    chk("start_wait", busy, 0);
    do_move(4'b1000, 1'b1);
    do_move(4'b0100, 1'b0);
    do_move(4'b0001, 1'b0);
    goto(0, 5);
    do_move(4'b0100, 1'b0);
    foreach (mem[i]) mem[i] = ($urandom_range(0, 3) != 0);
    for (int i = 0; i < 200; i++) do_move(4'($urandom_range(0, 15)), 1'($urandom_range(0, 1)));
    foreach (mem[i]) mem[i] = 1'b1;
    goto(28, 38);
    do_move(4'b0010, 1'b0);
    for (int i = 0; i < 120 && mc < 99; i++) begin
      goto(28, 38);
      do_move(4'b0010, 1'b0);
    end
    goto(28, 38);
    do_move(4'b0010, 1'b0);
    chk("saturate", mazes_complete, 99);
    wait_ready();
    direction = 4'b1000;
    tick();
    direction = 4'b0000;
    tick();
    timer_end = 1'b1;
    tick();
    chk("timer_busy", busy, 1);
    pos("timer");
    direction = 4'b1000;
    repeat (5) tick();
    pos("timer_hold");
    chk("timer_hold_busy", busy, 1);
    chk("timer_no_pulse", exit_reached, 0);
    direction = 4'b0000;
    timer_end = 1'b0;
    tick();
    chk("timer_release", busy, 0);
    do_move(4'b1000, 1'b0);
    wait_ready();
    direction = 4'b1000;
    tick();
    direction = 4'b0000;
    maze_valid = 1'b0;
    tick();
    mx = 1;
    my = 1;
    pos("abort");
    chk("abort_busy", busy, 1);
    maze_valid = 1'b1;
    tick();
    chk("abort_rearm", busy, 0);
    direction = 4'b1000;
    tick();
    direction = 4'b0000;
    repeat (3) tick();
    chk("cool_x", player_x, 2);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    chk("rst2_x", player_x, 1);
    chk("rst2_y", player_y, 1);
    chk("rst2_mazes", mazes_complete, 0);
    chk("rst2_exit", exit_reached, 0);
    chk("rst2_regen", regen_req, 0);
    chk("rst2_busy", busy, 1);
    chk("rst2_addr", maze_addr, 1 + W);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
